// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous display updates.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    pending,
   output logic                    upd_ack
);

   localparam int VW = 4 * NUM_DIGITS;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;
   logic [VW-1:0]         r_active_val;
   logic [NUM_DIGITS-1:0] r_active_dp;
   logic [VW-1:0]         r_shadow_val;
   logic [NUM_DIGITS-1:0] r_shadow_dp;
   logic                  r_pending;
   logic                  r_ack;
   logic [6:0]            r_seg_n;
   logic                  r_dp_n;
   logic [NUM_DIGITS-1:0] r_an_n;

   logic                  w_wrap;
   logic                  w_frame;
   logic [3:0]            w_nib;
   logic                  w_dp;
   logic [NUM_DIGITS-1:0] w_an_n;
   logic [6:0]            w_glyph;

   assign w_wrap  = (r_presc == PRESC_MAX);
   assign w_frame = w_wrap && (r_idx == IDX_MAX);

   // Scan timing: prescaler and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (w_wrap) begin
         r_presc <= '0;
         r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // Shadow/active double buffer; an incoming load at the boundary bypasses the shadow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active_val <= '0;
         r_active_dp  <= '0;
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_pending    <= 1'b0;
         r_ack        <= 1'b0;
      end else begin
         r_ack <= w_frame && (r_pending || load);
         if (w_frame) begin
            if (load) begin
               r_active_val <= value;
               r_active_dp  <= dp;
            end else if (r_pending) begin
               r_active_val <= r_shadow_val;
               r_active_dp  <= r_shadow_dp;
            end
            r_pending <= 1'b0;
         end else if (load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp;
            r_pending    <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nib  = 4'h0;
      w_dp   = 1'b0;
      w_an_n = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib     = r_active_val[i*4 +: 4];
            w_dp      = r_active_dp[i];
            w_an_n[i] = 1'b0;
         end
      end
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [IW-1:0] w_msd;

   // Highest nonzero nibble; an all-zero value leaves digit 0 as the only lit digit
   always_comb begin
      w_msd = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_active_val[i*4 +: 4] != 4'h0) begin
            w_msd = IW'(i);
         end
      end
   end

   assign w_glyph = (r_idx > w_msd) ? 7'h7F : hex_glyph(w_nib);
`else
   assign w_glyph = hex_glyph(w_nib);
`endif

   // Output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg_n <= 7'h7F;
         r_dp_n  <= 1'b1;
         r_an_n  <= '1;
      end else if (blank) begin
         r_seg_n <= 7'h7F;
         r_dp_n  <= 1'b1;
         r_an_n  <= '1;
      end else begin
         r_seg_n <= w_glyph;
         r_dp_n  <= ~w_dp;
         r_an_n  <= w_an_n;
      end
   end

   assign seg_n   = r_seg_n;
   assign dp_n    = r_dp_n;
   assign an_n    = r_an_n;
   assign pending = r_pending;
   assign upd_ack = r_ack;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-003 Parameter SCAN_DIV, default 50000, clock cycles each digit is driven; legal minimum 2.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load  input  1  single-cycle request to capture value and dp.
REQ-007 value  input  4*NUM_DIGITS  hex nibbles; value[3:0] is digit 0, the rightmost digit.
REQ-008 dp  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 blank  input  1  1 = display dark.
REQ-010 seg_n  output  7  active-low segments; bit0 = a through bit6 = g.
REQ-011 dp_n  output  1  active-low decimal point of the driven digit.
REQ-012 an_n  output  NUM_DIGITS  active-low digit enable; one-hot-low or all ones.
REQ-013 pending  output  1  a captured value is waiting for the frame boundary.
REQ-014 upd_ack  output  1  one-cycle pulse when the waiting value becomes displayed.

Function
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-016 The digit index SHALL advance on the prescaler wrap, running 0..NUM_DIGITS-1 and then wrapping to 0.
REQ-017 A frame boundary is the cycle where the prescaler = SCAN_DIV-1 and the index = NUM_DIGITS-1.
REQ-018 When load=1 at a clock edge, value and dp SHALL be captured into a shadow register and pending SHALL be set.
REQ-019 A later load while pending is set SHALL overwrite the shadow register; the last load wins.
REQ-020 At a frame boundary with pending=1, the shadow register SHALL copy into the active register, pending SHALL clear, and upd_ack SHALL be 1 for exactly the following cycle.
REQ-021 When load coincides with a frame boundary, the incoming value SHALL go straight to active, pending SHALL stay 0, and upd_ack SHALL pulse.
REQ-022 seg_n, dp_n and an_n SHALL be registered and SHALL change on the same edge, one cycle after the index or active register changes.
REQ-023 seg_n glyphs (hex of seg_n[6:0]) SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-024 When blank=1: an_n SHALL be all ones, seg_n = 7F and dp_n = 1 from the next edge; scanning, load and update SHALL continue unaffected.
REQ-025 With NUM_DIGITS = 1, an_n SHALL stay 0 while not blanked, and every prescaler wrap SHALL be a frame boundary.

Reset
REQ-026 While rst=1, the block SHALL hold: prescaler 0, index 0, active and shadow registers 0, pending 0, upd_ack 0, an_n all ones, seg_n 7F, dp_n 1.
REQ-027 Reset asserted mid-frame or while pending is set SHALL discard the shadow value without an upd_ack pulse.
REQ-028 On the first edge after rst falls, the block SHALL drive digit 0 showing 0 (seg_n 40).

Configuration
REQ-029 Macro SEG_LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-030 With the macro defined: for each digit above the most-significant nonzero active nibble, seg_n = 7F, dp_n still follows dp, and an_n scans normally; digit 0 SHALL never be blanked.
REQ-031 With the macro undefined, every digit SHALL show its glyph; no blanking logic is present.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-032 Reset release, no load -> an_n cycles E,D,B,7 every 4 cycles; seg_n = 40 throughout; upd_ack = 0.
REQ-033 Load 0x12AF mid-frame -> pending=1; at next boundary upd_ack pulses once; digits 0..3 show 0E, 08, 24, 79.
REQ-034 Load 0x1111 then 0x2222 in the same frame -> one upd_ack; display shows 24 on all digits; 0x1111 is never shown.
REQ-035 Load coincident with boundary -> pending stays 0; upd_ack next cycle; new value is shown from digit 0.
REQ-036 blank=1 for 20 cycles -> an_n=F, seg_n=7F, dp_n=1; after release the scan phase matches an unblanked reference count.
REQ-037 Macro defined, value 0x0050, dp=0 -> digits 3 and 2 have seg_n 7F, digit 1 = 12, digit 0 = 40; rst pulse mid-frame with pending -> REQ-026 state and no upd_ack.
